// File: rtl/pci_tx_pkg.sv
// Shared transmit-layer definitions: VC arbiter state encodings, routing default
// and the arbitration next-state rule.
package pci_tx_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GNT_VC0 = 2'd1,
        ARB_GNT_VC1 = 2'd2,
        ARB_STALL   = 2'd3
    } arb_state_e;

    localparam int DEST_BIT_DEFAULT = 4;

    // Stall is deliberately not qualified by the head word's destination.
    function automatic arb_state_e arb_next_state(
        input logic stall,
        input logic vc0_empty,
        input logic vc1_empty,
        input logic force_vc1
    );
        arb_state_e nxt;
        if (stall && (!vc0_empty || !vc1_empty)) begin
            nxt = ARB_STALL;
        end else if (!vc0_empty && !force_vc1) begin
            nxt = ARB_GNT_VC0;
        end else if (!vc1_empty && (vc0_empty || force_vc1)) begin
            nxt = ARB_GNT_VC1;
        end else begin
            nxt = ARB_IDLE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vc_arbiter_if.sv
// Handshake bundle between the VC arbiter and its VC/D FIFOs.
// master = arbiter side, slave = FIFO side.
interface vc_arbiter_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic [DATA_WIDTH-1:0] vc0_data;
    logic [DATA_WIDTH-1:0] vc1_data;
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic                  d0_full;
    logic                  d1_full;
    logic                  pop_vc0;
    logic                  pop_vc1;
    logic                  push_d0;
    logic                  push_d1;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        input  vc0_empty, vc1_empty, vc0_data, vc1_data,
        input  d0_almost_full, d1_almost_full, d0_full, d1_full,
        output pop_vc0, pop_vc1, push_d0, push_d1, data_out
    );

    modport slave (
        output vc0_empty, vc1_empty, vc0_data, vc1_data,
        output d0_almost_full, d1_almost_full, d0_full, d1_full,
        input  pop_vc0, pop_vc1, push_d0, push_d1, data_out
    );

endinterface

// File: rtl/arb_starve_guard.sv
// Starvation guard for the VC arbiter: counts consecutive VC0 grants while VC1
// waits and forces a VC1 grant once the streak reaches VC0_WEIGHT.
module arb_starve_guard #(
    parameter int VC0_WEIGHT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic init,
    input  logic vc1_empty,
    input  logic gnt_vc0,
    input  logic gnt_vc1,
    output logic force_vc1
);

    localparam int STREAK_W = $clog2(VC0_WEIGHT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VC0_WEIGHT);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    // Saturating at the weight keeps the counter from wrapping if VC1 stalls out.
    always_comb begin
        streak_d = streak_q;
        if (!init || vc1_empty || gnt_vc1) begin
            streak_d = '0;
        end else if (gnt_vc0 && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_vc1 = (streak_q == STREAK_MAX) && !vc1_empty;

endmodule

// File: rtl/vc_arbiter.sv
// Two-VC to two-destination arbiter: VC0 priority, 2-cycle pop-to-push route pipeline.
// Define ARB_STARVE_GUARD_EN to bound consecutive VC0 grants while VC1 waits.
module vc_arbiter
    import pci_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = DEST_BIT_DEFAULT,
    parameter int VC0_WEIGHT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    vc_arbiter_if.master      bus,
    output logic [1:0]        arb_state,
    output logic              arb_error
);

    if ((DEST_BIT >= DATA_WIDTH) || (VC0_WEIGHT < 1)) begin : g_param_check
        $error("vc_arbiter: DEST_BIT must index the word and VC0_WEIGHT must be at least 1");
    end

    arb_state_e            next_state;
    arb_state_e            state_q, state_d;
    logic                  stall;
    logic                  force_vc1;
    logic                  pop_vc0;
    logic                  pop_vc1;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_src_q, rd_src_d;
    logic                  push_d0_q, push_d0_d;
    logic                  push_d1_q, push_d1_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  arb_error_q, arb_error_d;
    logic [DATA_WIDTH-1:0] rd_word;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_guard #(
        .VC0_WEIGHT (VC0_WEIGHT)
    ) u_starve_guard (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .vc1_empty (bus.vc1_empty),
        .gnt_vc0   (pop_vc0),
        .gnt_vc1   (pop_vc1),
        .force_vc1 (force_vc1)
    );
`else
    assign force_vc1 = 1'b0;
`endif

    // Stage 1 remembers which VC was popped; the FIFO word is valid one cycle
    // later and is routed into the registered push outputs in stage 2.
    always_comb begin
        stall       = bus.d0_almost_full | bus.d1_almost_full;
        next_state  = arb_next_state(stall, bus.vc0_empty, bus.vc1_empty, force_vc1);
        pop_vc0     = reset && init && (next_state == ARB_GNT_VC0);
        pop_vc1     = reset && init && (next_state == ARB_GNT_VC1);
        rd_word     = rd_src_q ? bus.vc1_data : bus.vc0_data;

        state_d     = next_state;
        rd_valid_d  = pop_vc0 | pop_vc1;
        rd_src_d    = pop_vc1;
        push_d0_d   = rd_valid_q & ~rd_word[DEST_BIT];
        push_d1_d   = rd_valid_q &  rd_word[DEST_BIT];
        data_out_d  = rd_valid_q ? rd_word : data_out_q;
        arb_error_d = arb_error_q | (push_d0_q & bus.d0_full) | (push_d1_q & bus.d1_full);

        if (!init) begin
            state_d     = ARB_IDLE;
            rd_valid_d  = 1'b0;
            rd_src_d    = 1'b0;
            push_d0_d   = 1'b0;
            push_d1_d   = 1'b0;
            data_out_d  = '0;
            arb_error_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            rd_valid_q  <= 1'b0;
            rd_src_q    <= 1'b0;
            push_d0_q   <= 1'b0;
            push_d1_q   <= 1'b0;
            data_out_q  <= '0;
            arb_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_valid_q  <= rd_valid_d;
            rd_src_q    <= rd_src_d;
            push_d0_q   <= push_d0_d;
            push_d1_q   <= push_d1_d;
            data_out_q  <= data_out_d;
            arb_error_q <= arb_error_d;
        end
    end

    assign bus.pop_vc0  = pop_vc0;
    assign bus.pop_vc1  = pop_vc1;
    assign bus.push_d0  = push_d0_q;
    assign bus.push_d1  = push_d1_q;
    assign bus.data_out = data_out_q;
    assign arb_state    = state_q;
    assign arb_error    = arb_error_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Scoreboard bench for vc_arbiter: behavioural VC FIFOs feed the DUT, expected
// pushes are queued by the stimulus and checked by an independent monitor.
module tb_vc_arbiter;
    import pci_tx_pkg::*;

    localparam int DW = 6;

    typedef struct packed {
        logic          dest;
        logic [DW-1:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [1:0] arb_state;
    logic       arb_error;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int push_cnt = 0;

    exp_t exp_q[$];
    int   gnt_log[$];
    int   gnt_cyc[$];
    int   push_cyc[$];

    logic [DW-1:0] vc0_mem [64];
    logic [DW-1:0] vc1_mem [64];
    int vc0_wr = 0;
    int vc0_rd = 0;
    int vc1_wr = 0;
    int vc1_rd = 0;

    vc_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    vc_arbiter #(
        .DATA_WIDTH (DW),
        .DEST_BIT   (4),
        .VC0_WEIGHT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .bus       (bus),
        .arb_state (arb_state),
        .arb_error (arb_error)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    assign bus.vc0_empty = (vc0_rd == vc0_wr);
    assign bus.vc1_empty = (vc1_rd == vc1_wr);

    // VC FIFO model: data appears the cycle after a pop; reset empties both FIFOs.
    initial begin
        bus.vc0_data = '0;
        bus.vc1_data = '0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                vc0_rd       <= vc0_wr;
                vc1_rd       <= vc1_wr;
                bus.vc0_data <= '0;
                bus.vc1_data <= '0;
            end else begin
                if (bus.pop_vc0) begin
                    bus.vc0_data <= vc0_mem[vc0_rd % 64];
                    vc0_rd       <= vc0_rd + 1;
                end
                if (bus.pop_vc1) begin
                    bus.vc1_data <= vc1_mem[vc1_rd % 64];
                    vc1_rd       <= vc1_rd + 1;
                end
            end
        end
    end

    // Monitor: logs grants, checks pop legality and scores every push.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && init === 1'b1) begin
                if (bus.pop_vc0 || bus.pop_vc1) begin
                    total++;
                    if ((bus.pop_vc0 && bus.pop_vc1) || (bus.pop_vc0 && bus.vc0_empty) ||
                        (bus.pop_vc1 && bus.vc1_empty)) begin
                        bad++;
                        $display("[TB] FAIL pop_legal: pop_vc0=%b pop_vc1=%b vc0_empty=%b vc1_empty=%b required one pop on a non-empty VC",
                                 bus.pop_vc0, bus.pop_vc1, bus.vc0_empty, bus.vc1_empty);
                    end
                    gnt_log.push_back(bus.pop_vc1 ? 1 : 0);
                    gnt_cyc.push_back(cyc);
                end
                if (bus.push_d0 || bus.push_d1) begin
                    push_cnt++;
                    push_cyc.push_back(cyc);
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL unexpected_push: push_d0=%b push_d1=%b data=%h required no push",
                                 bus.push_d0, bus.push_d1, bus.data_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.push_d0 !== ~e.dest || bus.push_d1 !== e.dest || bus.data_out !== e.data) begin
                            bad++;
                            $display("[TB] FAIL push_match: push_d0=%b push_d1=%b data=%h required push_d%0d data=%h",
                                     bus.push_d0, bus.push_d1, bus.data_out, e.dest, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, required the test to complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic apply_stimulus(input int vc, input logic [DW-1:0] w);
        if (vc == 0) begin
            vc0_mem[vc0_wr % 64] = w;
            vc0_wr++;
        end else begin
            vc1_mem[vc1_wr % 64] = w;
            vc1_wr++;
        end
    endtask

    task automatic expect_push(input logic dest, input logic [DW-1:0] w);
        exp_t e;
        e.dest = dest;
        e.data = w;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_output({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        step(3);
    endtask

    task automatic wait_grants(input string name, input int target, input int budget);
        int k = 0;
        while (gnt_log.size() < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_output({name, "_grants"}, (gnt_log.size() >= target) ? 1 : 0, 1);
    endtask

    task automatic check_grants(input string name, input int g0, input int order[$]);
        check_output({name, "_grant_count"}, gnt_log.size() - g0, order.size());
        if (gnt_log.size() - g0 >= order.size()) begin
            for (int i = 0; i < order.size(); i++) begin
                check_output($sformatf("%s_grant%0d", name, i), gnt_log[g0 + i], order[i]);
            end
        end
    endtask

    initial begin
        int g0;
        int p0;
        int snap;

        reset = 1'b0;
        init  = 1'b1;
        bus.d0_almost_full = 1'b0;
        bus.d1_almost_full = 1'b0;
        bus.d0_full        = 1'b0;
        bus.d1_full        = 1'b0;
        step(2);
        check_output("rst_arb_state", int'(arb_state), 0);
        check_output("rst_push", int'(bus.push_d0 | bus.push_d1), 0);
        check_output("rst_data_out", int'(bus.data_out), 0);
        check_output("rst_arb_error", int'(arb_error), 0);
        reset = 1'b1;
        step(1);

        // Strict priority: all of VC0 before any VC1.
        g0 = gnt_log.size();
        p0 = push_cyc.size();
        apply_stimulus(0, 6'h01); apply_stimulus(0, 6'h12); apply_stimulus(0, 6'h03);
        apply_stimulus(1, 6'h14); apply_stimulus(1, 6'h05); apply_stimulus(1, 6'h16);
        expect_push(1'b0, 6'h01); expect_push(1'b1, 6'h12); expect_push(1'b0, 6'h03);
        expect_push(1'b1, 6'h14); expect_push(1'b0, 6'h05); expect_push(1'b1, 6'h16);
        drain("prio", 40);
        check_grants("prio", g0, '{0, 0, 0, 1, 1, 1});
        if (push_cyc.size() >= p0 + 6 && gnt_cyc.size() > g0) begin
            check_output("prio_latency", push_cyc[p0] - gnt_cyc[g0], 2);
            check_output("prio_push_span", push_cyc[p0 + 5] - push_cyc[p0], 5);
        end else begin
            check_output("prio_push_count", push_cyc.size() - p0, 6);
        end

        // Routing by bit 4, then data_out holds when idle.
        apply_stimulus(0, 6'h10); apply_stimulus(0, 6'h01);
        expect_push(1'b1, 6'h10); expect_push(1'b0, 6'h01);
        drain("route", 30);
        check_output("route_hold_data", int'(bus.data_out), 6'h01);
        check_output("route_idle_push", int'(bus.push_d0 | bus.push_d1), 0);
        check_output("route_idle_state", int'(arb_state), 0);

        // Backpressure raised after two grants with both VCs non-empty.
        g0 = gnt_log.size();
        apply_stimulus(0, 6'h21); apply_stimulus(0, 6'h02); apply_stimulus(0, 6'h23); apply_stimulus(0, 6'h04);
        apply_stimulus(1, 6'h15); apply_stimulus(1, 6'h06);
        expect_push(1'b0, 6'h21); expect_push(1'b0, 6'h02); expect_push(1'b0, 6'h23);
        expect_push(1'b0, 6'h04); expect_push(1'b1, 6'h15); expect_push(1'b0, 6'h06);
        wait_grants("bp", g0 + 2, 20);
        bus.d0_almost_full = 1'b1;
        snap = push_cnt;
        step(1);
        check_output("bp_state", int'(arb_state), 3);
        check_output("bp_pops", int'(bus.pop_vc0 | bus.pop_vc1), 0);
        step(4);
        check_output("bp_push_bound", (push_cnt - snap <= 2) ? 1 : 0, 1);
        check_output("bp_no_grant", gnt_log.size() - g0, 2);
        bus.d0_almost_full = 1'b0;
        #1;
        check_output("bp_resume_pop", int'(bus.pop_vc0), 1);
        step(1);
        check_output("bp_resume_state", int'(arb_state), 1);
        drain("bp", 40);
        check_grants("bp", g0, '{0, 0, 0, 0, 1, 1});

        // Reset mid-stream drops in-flight words.
        g0 = gnt_log.size();
        apply_stimulus(0, 6'h11); apply_stimulus(0, 6'h22); apply_stimulus(0, 6'h33);
        wait_grants("mid_rst", g0 + 2, 20);
        reset = 1'b0;
        #1;
        check_output("mid_rst_push", int'(bus.push_d0 | bus.push_d1), 0);
        check_output("mid_rst_data_out", int'(bus.data_out), 0);
        check_output("mid_rst_state", int'(arb_state), 0);
        check_output("mid_rst_pops", int'(bus.pop_vc0 | bus.pop_vc1), 0);
        step(2);
        reset = 1'b1;
        snap = push_cnt;
        step(8);
        check_output("post_rst_no_push", push_cnt - snap, 0);
        check_output("post_rst_state", int'(arb_state), 0);

        // Sticky error: only a push into a full destination sets it; init clears it.
        check_output("err_initial", int'(arb_error), 0);
        bus.d0_full = 1'b1;
        apply_stimulus(1, 6'h16);
        expect_push(1'b1, 6'h16);
        drain("err_d1", 30);
        check_output("err_d1_no_error", int'(arb_error), 0);
        apply_stimulus(0, 6'h02);
        expect_push(1'b0, 6'h02);
        drain("err_d0", 30);
        check_output("err_set", int'(arb_error), 1);
        bus.d0_full = 1'b0;
        step(3);
        check_output("err_sticky", int'(arb_error), 1);
        init = 1'b0;
        step(1);
        check_output("init_error_clear", int'(arb_error), 0);
        check_output("init_data_out", int'(bus.data_out), 0);
        check_output("init_state", int'(arb_state), 0);
        init = 1'b1;
        step(2);
        check_output("init_error_stays", int'(arb_error), 0);

`ifdef ARB_STARVE_GUARD_EN
        // Guard: VC1 gets one grant after every four consecutive VC0 grants.
        g0 = gnt_log.size();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, DW'(i));
        end
        apply_stimulus(1, 6'h10); apply_stimulus(1, 6'h11);
        for (int i = 0; i < 4; i++) expect_push(1'b0, DW'(i));
        expect_push(1'b1, 6'h10);
        for (int i = 4; i < 8; i++) expect_push(1'b0, DW'(i));
        expect_push(1'b1, 6'h11);
        for (int i = 8; i < 10; i++) expect_push(1'b0, DW'(i));
        drain("guard", 60);
        check_grants("guard", g0, '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
